pipe_ifid: RTL and testbench
============================

Name: pipe_ifid

Overview:
- IF/ID pipeline stage directly downstream of the fetch stage.
- Captures {pc, instr} pairs from fetch through a 2-entry skid buffer and presents them to decode with a valid/ready handshake.
- Drives the PC-register enable so fetch stalls when the buffer is full.
- Branch/jump resolution can discard buffered instructions with a flush.

Parameters:
- ADDR_W, 32, PC width in bits.
- INSTR_W, 32, instruction width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_pc  input  ADDR_W  PC of the fetched instruction.
- in_instr  input  INSTR_W  fetched instruction word.
- in_ready  output  1  buffer can accept this cycle.
- pc_ena  output  1  PC-register enable to fetch; identical to in_ready.
- flush  input  1  discard all buffered and incoming instructions.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  ADDR_W  PC of the head entry.
- out_pc4  output  ADDR_W  out_pc + 4, truncated to ADDR_W, no carry out.
- out_instr  output  INSTR_W  head instruction.

Behaviour:
- State machine, one-hot or binary encoding (implementer's choice): EMPTY (0 entries), ONE (head valid), TWO (head + skid valid).
- Outputs are driven directly from registers or their +4 adder:
  - in_ready = (state != TWO).
  - pc_ena = (state != TWO).
  - out_valid = (state != EMPTY).
  - out_pc, out_instr come from the head register.
- Handshakes:
  - acc = in_valid & in_ready.
  - drn = out_valid & out_ready.
- Transitions when flush = 0:
  - EMPTY, acc: head <= in; go to ONE.
  - ONE, acc & !drn: skid <= in; go to TWO.
  - ONE, acc & drn: head <= in; stay in ONE.
  - ONE, !acc & drn: go to EMPTY.
  - TWO, drn: head <= skid; go to ONE. acc is impossible in TWO.
  - All other cases hold state and data.
- Flush has the highest priority:
  - Next state is EMPTY regardless of acc or drn.
  - An in_valid beat in the flush cycle is discarded and never appears at the output.
  - A drn in the flush cycle still counts as consumed by decode.
- Latency: a beat accepted at edge N is visible with out_valid = 1 after edge N.
- Order is strictly FIFO; no beat is ever duplicated or dropped except by flush.
- Reset (rst = 0, asynchronous):
  - state = EMPTY, so out_valid = 0 and in_ready = pc_ena = 1.
  - head, skid, out_pc and out_instr = 0; out_pc4 = 4.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Data registers load only on the transitions listed above; in particular, the skid register must not change while in ONE without acc.
- out_pc4 wraps modulo 2^ADDR_W: in_pc = 0xFFFFFFFC gives out_pc4 = 0x00000000.

Optional Feature:
- Macro IFID_PREDECODE_EN.
- Defined: adds three registered output ports, each 1 bit wide, which travel with the entry through head and skid and reset to 0:
  - out_is_br = 1 for opcode [31:26] = 6'b000100 or 6'b000101.
  - out_is_j = 1 for opcode = 6'b000010 or 6'b000011.
  - out_is_jr = 1 for opcode = 6'b000000 with funct [5:0] = 6'b001000.
- Not defined: the ports do not exist; behaviour and timing are otherwise identical.

Decomposition:
- Shared header/package holds:
  - the opcode and funct constants (OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_RTYPE, FN_JR);
  - the state encodings for EMPTY, ONE and TWO.
- One natural sub-module, ifid_entry: an enabled register holding {pc, instr[, predecode bits]}, instantiated twice as head and skid.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, in_ready = 1, pc_ena = 1, out_pc = 0, out_pc4 = 4; after release, the first accepted beat appears one edge later.
- Streaming: out_ready = 1, send pc = 0x00,0x04,0x08,0x0C -> identical sequence on out_pc, one per cycle; in_ready never drops.
- Backpressure: out_ready = 0, send pc = 0x10 then 0x14 -> state TWO, in_ready = pc_ena = 0, the 0x18 beat is held off; raise out_ready -> outputs 0x10, 0x14, 0x18 in order with no loss or duplication.
- Flush: buffer in TWO holding 0x20,0x24, assert flush with in_valid = 1, pc = 0x28 -> next cycle out_valid = 0, in_ready = 1; 0x28 never appears at the output.
- Wrap: send in_pc = 0xFFFFFFFC -> out_pc4 = 0x00000000.
- Predecode (IFID_PREDECODE_EN): send instrs 0x10220003, 0x08000004, 0x03E00008 -> out_is_br, out_is_j and out_is_jr set respectively, one per beat, all others 0.

Source files
------------

// File: rtl/pipe_ifid_pkg.sv
// Shared types and constants for the IF/ID stage: buffer state encoding,
// instruction opcode/funct constants and the predecode helper.
package pipe_ifid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam int PD_W = 3;

    // Returns {is_br, is_j, is_jr} for one instruction word.
    function automatic logic [PD_W-1:0] predecode(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        logic       is_br;
        logic       is_j;
        logic       is_jr;
        op    = instr[31:26];
        fn    = instr[5:0];
        is_br = (op == OP_BEQ) || (op == OP_BNE);
        is_j  = (op == OP_J) || (op == OP_JAL);
        is_jr = (op == OP_RTYPE) && (fn == FN_JR);
        return {is_br, is_j, is_jr};
    endfunction

endpackage

// File: rtl/pipe_ifid_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID stage.
// Predecode flags exist only when IFID_PREDECODE_EN is defined.
interface pipe_ifid_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    // Valid/ready: a beat moves on a rising edge where valid and ready are both 1;
    // valid and payload hold until then, and ready never depends on valid.
    logic               in_valid;
    logic [ADDR_W-1:0]  in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               pc_ena;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc4;
    logic [INSTR_W-1:0] out_instr;
`ifdef IFID_PREDECODE_EN
    logic               out_is_br;
    logic               out_is_j;
    logic               out_is_jr;
`endif

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, pc_ena, out_valid, out_pc, out_pc4, out_instr
`ifdef IFID_PREDECODE_EN
        , input out_is_br, out_is_j, out_is_jr
`endif
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, pc_ena, out_valid, out_pc, out_pc4, out_instr
`ifdef IFID_PREDECODE_EN
        , output out_is_br, out_is_j, out_is_jr
`endif
    );

endinterface

// File: rtl/pipe_ifid_entry.sv
// One buffer slot: an enabled register holding a packed {pc, instr[, predecode]}.
module ifid_entry #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_ifid.sv
// IF/ID stage: 2-entry skid buffer between fetch and decode with flush.
// Optional predecode flags are enabled by defining IFID_PREDECODE_EN.
module pipe_ifid
    import pipe_ifid_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    pipe_ifid_if.slave bus,
    output state_t o_dbg_state
);

`ifdef IFID_PREDECODE_EN
    localparam int ENT_W = ADDR_W + INSTR_W + PD_W;
`else
    localparam int ENT_W = ADDR_W + INSTR_W;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_acc;
    logic               w_drn;
    logic               w_head_en;
    logic               w_skid_en;
    logic [ENT_W-1:0]   w_in_ent;
    logic [ENT_W-1:0]   w_head_d;
    logic [ENT_W-1:0]   w_head_q;
    logic [ENT_W-1:0]   w_skid_q;
    logic [ADDR_W-1:0]  w_head_pc;

    assign w_acc = bus.in_valid & r_in_ready;
    assign w_drn = r_out_valid & bus.out_ready;

`ifdef IFID_PREDECODE_EN
    assign w_in_ent = {predecode(bus.in_instr), bus.in_pc, bus.in_instr};
`else
    assign w_in_ent = {bus.in_pc, bus.in_instr};
`endif

    // Flush blocks every data load so a flushed beat never reaches head or skid.
    always_comb begin
        w_state_nxt = r_state;
        w_head_en   = 1'b0;
        w_skid_en   = 1'b0;
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_head_en   = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && !w_drn) begin
                        w_skid_en   = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_acc && w_drn) begin
                        w_head_en   = 1'b1;
                    end else if (w_drn) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drn) begin
                        w_head_en   = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Head refills from skid when draining out of TWO, otherwise from fetch.
    assign w_head_d = (r_state == ST_TWO) ? w_skid_q : w_in_ent;

    ifid_entry #(.W(ENT_W)) u_head (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_head_en),
        .i_d   (w_head_d),
        .o_q   (w_head_q)
    );

    ifid_entry #(.W(ENT_W)) u_skid (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_skid_en),
        .i_d   (w_in_ent),
        .o_q   (w_skid_q)
    );

    assign w_head_pc     = w_head_q[INSTR_W +: ADDR_W];
    assign bus.in_ready  = r_in_ready;
    assign bus.pc_ena    = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pc    = w_head_pc;
    assign bus.out_pc4   = w_head_pc + ADDR_W'(4);
    assign bus.out_instr = w_head_q[INSTR_W-1:0];
`ifdef IFID_PREDECODE_EN
    assign bus.out_is_br = w_head_q[ENT_W-1];
    assign bus.out_is_j  = w_head_q[ENT_W-2];
    assign bus.out_is_jr = w_head_q[ENT_W-3];
`endif
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pipe_ifid.sv
// Directed bench for pipe_ifid: reset, streaming, backpressure, flush, wrap,
// and predecode flags when IFID_PREDECODE_EN is defined.
module tb_pipe_ifid;
    import pipe_ifid_pkg::*;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_chk;
    int     n_pass;
    int     n_fail;

    pipe_ifid_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    pipe_ifid #(.ADDR_W(32), .INSTR_W(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t exp);
        check(tag, {30'd0, dbg_state}, {30'd0, exp});
    endtask

    // Inputs change and outputs are checked at falling edges only.
    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h0000_0100;
        bus.in_instr  = 32'h1234_5678;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held for 3 cycles with in_valid high
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_pc_ena",    {31'd0, bus.pc_ena},    32'd1);
        check("rst_out_pc",    bus.out_pc,             32'h0);
        check("rst_out_pc4",   bus.out_pc4,            32'h4);
        check("rst_out_instr", bus.out_instr,          32'h0);
        check_state("rst_state", ST_EMPTY);
        rst = 1'b1;
        @(negedge clk);
        check("first_valid", {31'd0, bus.out_valid}, 32'd1);
        check("first_pc",    bus.out_pc,             32'h100);
        check("first_pc4",   bus.out_pc4,            32'h104);
        check("first_instr", bus.out_instr,          32'h1234_5678);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("first_drain", {31'd0, bus.out_valid}, 32'd0);

        // Streaming with decode always ready
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pc    = 32'(i * 4);
            bus.in_instr = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            check("stream_pc",    bus.out_pc,                32'(i * 4));
            check("stream_instr", bus.out_instr,             32'hA000_0000 + 32'(i));
            check("stream_valid", {31'd0, bus.out_valid},    32'd1);
            check("stream_ready", {31'd0, bus.in_ready},     32'd1);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stream_empty", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure fills both entries
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h10;
        @(negedge clk);
        check_state("bp_one", ST_ONE);
        bus.in_pc = 32'h14;
        @(negedge clk);
        check_state("bp_two", ST_TWO);
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp_pc_ena",   {31'd0, bus.pc_ena},   32'd0);
        check("bp_head",     bus.out_pc,            32'h10);
        bus.in_pc = 32'h18;
        @(negedge clk);
        check_state("bp_hold", ST_TWO);
        check("bp_hold_head", bus.out_pc, 32'h10);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_out1",    bus.out_pc,            32'h14);
        check("bp_ready1",  {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        check("bp_out2",    bus.out_pc,             32'h18);
        check("bp_valid2",  {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush from TWO with a beat offered in the same cycle
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h20;
        @(negedge clk);
        bus.in_pc = 32'h24;
        @(negedge clk);
        check_state("fl_two", ST_TWO);
        check("fl_head", bus.out_pc, 32'h20);
        bus.flush = 1'b1;
        bus.in_pc = 32'h28;
        @(negedge clk);
        check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl_ready", {31'd0, bus.in_ready},  32'd1);
        check_state("fl_state", ST_EMPTY);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("fl_no_28", {31'd0, bus.out_valid}, 32'd0);

        // PC wrap, then hold in ONE with neither accept nor drain
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_pc",  bus.out_pc,  32'hFFFF_FFFC);
        check("wrap_pc4", bus.out_pc4, 32'h0000_0000);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_state("hold_one", ST_ONE);
        check("hold_pc", bus.out_pc, 32'hFFFF_FFFC);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("hold_drain", {31'd0, bus.out_valid}, 32'd0);

`ifdef IFID_PREDECODE_EN
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h40;
        bus.in_instr = 32'h1022_0003;
        @(negedge clk);
        check("pd_br_br", {31'd0, bus.out_is_br}, 32'd1);
        check("pd_br_j",  {31'd0, bus.out_is_j},  32'd0);
        check("pd_br_jr", {31'd0, bus.out_is_jr}, 32'd0);
        bus.in_instr = 32'h0800_0004;
        @(negedge clk);
        check("pd_j_br", {31'd0, bus.out_is_br}, 32'd0);
        check("pd_j_j",  {31'd0, bus.out_is_j},  32'd1);
        check("pd_j_jr", {31'd0, bus.out_is_jr}, 32'd0);
        bus.in_instr = 32'h03E0_0008;
        @(negedge clk);
        check("pd_jr_br", {31'd0, bus.out_is_br}, 32'd0);
        check("pd_jr_j",  {31'd0, bus.out_is_j},  32'd0);
        check("pd_jr_jr", {31'd0, bus.out_is_jr}, 32'd1);
        bus.in_valid = 1'b0;
        @(negedge clk);
`endif

        // Asynchronous reset mid-operation drops the entry before any edge
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h50;
        @(negedge clk);
        check("arst_pre", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_pc",    bus.out_pc,             32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
